trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Parametrised trap-entry/trap-return sequencer for the interrupt pipeline. Prioritises synchronous exceptions and asynchronous interrupts across a configurable number of cause lines, applies M/S delegation, and owns the trap CSR state (epc/cause/tval, interrupt-enable stack, current privilege). A multi-cycle FSM flushes the pipeline, commits state, then issues a single redirect to the trap vector, or to the saved epc on MRET/SRET.

## Interface
- XLEN, 32, data/address width
- NUM_EXC, 16, exception cause lines (cause code = bit index), 1..XLEN-1
- NUM_IRQ, 16, interrupt cause lines (cause code = bit index), 1..XLEN-1
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- exc_req  in  NUM_EXC  exception requests; lowest index wins
- irq_req  in  NUM_IRQ  level interrupt requests, pre-masked by mie; lowest index wins
- cur_pc  in  XLEN  pc of oldest uncommitted instruction (saved as epc)
- exc_tval  in  XLEN  trap value accompanying exc_req
- mret, sret  in  1 each  xRET retiring
- mtvec, stvec, medeleg, mideleg  in  XLEN each  CSR values
- flush_ack  in  1  pipeline drained
- flush  out  1  pipeline flush request
- redirect_valid  out  1  one-cycle fetch redirect strobe
- redirect_pc  out  XLEN  redirect target
- busy  out  1  state != IDLE
- priv_mode  out  2  00 U, 01 S, 11 M
- mepc, mcause, mtval, sepc, scause, stval  out  XLEN each  trap CSRs
- mie_g, mpie, sie_g, spie  out  1 each  status enable bits
- mpp  out  2; spp  out  1  previous-privilege fields

## Operation
- States: IDLE, FLUSH, COMMIT, REDIRECT. busy = state != IDLE.
- Event selection is done in IDLE only; all inputs are ignored while busy, so requests must be held by the pipeline.
- Same-cycle priority order: exception, then mret, then sret, then interrupt.
- xRET privilege check: mret with priv != M, or sret with priv == U, becomes exception cause 2 with tval 0.
- Interrupt eligibility, cause i:
  - Target S if mideleg[i] and priv != M; otherwise target M.
  - M-target taken if priv != M or mie_g.
  - S-target taken if priv == U, or (priv == S and sie_g).
  - Ineligible interrupts stay pending.
- Exception delegation: target S if medeleg[code] and priv != M; otherwise M.
- On selection, latch event kind, code, target, cur_pc and exc_tval; go to FLUSH.
- FLUSH: flush=1 until flush_ack is sampled high, then COMMIT.
- COMMIT, trap to M:
  - mepc=cur_pc; mcause={intr, code zero-extended}, intr in bit XLEN-1
  - mtval = exc_tval for exceptions, 0 for interrupts
  - mpie=mie_g, mie_g=0, mpp=priv, priv=M
- COMMIT, trap to S: the same with s-registers; spp=priv[0]; priv=S.
- COMMIT, mret: priv=mpp, mie_g=mpie, mpie=1, mpp=U.
- COMMIT, sret: priv={1'b0,spp}, sie_g=spie, spie=1, spp=0.
- REDIRECT: redirect_valid=1 for one cycle, then IDLE.
- redirect_pc:
  - Exceptions: {tvec[XLEN-1:2],2'b00}.
  - Interrupts: same base, plus 4*code when tvec[0]=1.
  - mret: mepc. sret: sepc.
  - Vector arithmetic is XLEN-bit, wraps modulo 2^XLEN.

## Timing
- Reset values:
  - State IDLE; flush=0, redirect_valid=0, busy=0, redirect_pc=0.
  - priv_mode=11; all epc/cause/tval = 0.
  - mie_g, mpie, sie_g, spie = 0; mpp=00; spp=0.
- Request sampled at edge T (IDLE) gives flush=1 from T+1.
- flush_ack high at the T+1 edge: COMMIT in cycle T+2, CSRs visible from T+3, redirect_valid in T+3, IDLE in T+4.
- Minimum event-to-event spacing is 4 cycles. Each cycle flush_ack is low adds one cycle.
- flush_ack outside FLUSH is ignored.
- Reset asserted in any state clears all outputs asynchronously; the in-flight event is dropped with no CSR update.

## Test plan
- Reset, then exc_req[2]=1, cur_pc=0x100, exc_tval=0xDEAD, mtvec=0x8000_0001, flush_ack tied 1 -> flush during T+1, mcause=2, mepc=0x100, mtval=0xDEAD, priv=11, redirect_pc=0x8000_0000 at T+3.
- priv=U, mie_g=0, irq_req[7]=1, mtvec=0x8000_0001 -> mcause=0x8000_0007, mtval=0, redirect_pc=0x8000_001C; mpp=00, mpie=0.
- priv=S, medeleg[8]=1, exc_req[8]=1, stvec=0x4000 -> scause=8, sepc=cur_pc, spp=1, priv=01, redirect 0x4000; repeat with priv=M -> mcause=8.
- exc_req[4] and irq_req[3] in the same IDLE cycle -> cause 4 taken. irq_req held -> interrupt taken only after mret restores mie_g=1.
- sret with priv=U -> mcause=2, mtval=0. mret with mpp=01, mepc=0x200 -> priv=01, redirect_pc=0x200, mpp=00, mpie=1.
- flush_ack held low 5 cycles, then rst pulsed in FLUSH -> no CSR change, all outputs return to reset values.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: selects exceptions, xRETs and interrupts in IDLE, then flushes the pipeline,
// commits the trap CSR state, and issues a single redirect to the trap vector or the saved epc.
module trap_sequencer #(
   parameter int XLEN    = 32,
   parameter int NUM_EXC = 16,
   parameter int NUM_IRQ = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_EXC-1:0] exc_req,
   input  logic [NUM_IRQ-1:0] irq_req,
   input  logic [XLEN-1:0]    cur_pc,
   input  logic [XLEN-1:0]    exc_tval,
   input  logic               mret,
   input  logic               sret,
   input  logic [XLEN-1:0]    mtvec,
   input  logic [XLEN-1:0]    stvec,
   input  logic [XLEN-1:0]    medeleg,
   input  logic [XLEN-1:0]    mideleg,
   input  logic               flush_ack,
   output logic               flush,
   output logic               redirect_valid,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               busy,
   output logic [1:0]         priv_mode,
   output logic [XLEN-1:0]    mepc,
   output logic [XLEN-1:0]    mcause,
   output logic [XLEN-1:0]    mtval,
   output logic [XLEN-1:0]    sepc,
   output logic [XLEN-1:0]    scause,
   output logic [XLEN-1:0]    stval,
   output logic               mie_g,
   output logic               mpie,
   output logic               sie_g,
   output logic               spie,
   output logic [1:0]         mpp,
   output logic               spp
);

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_M = 2'b11;

   typedef enum logic [1:0] {IDLE, FLUSH, COMMIT, REDIRECT} state_t;
   typedef enum logic [1:0] {EV_EXC, EV_IRQ, EV_MRET, EV_SRET} event_t;

   state_t            state;
   state_t            state_next;

   logic              exc_hit;
   logic [XLEN-1:0]   exc_code;
   logic              exc_to_s;
   logic              irq_hit;
   logic [XLEN-1:0]   irq_code;
   logic              irq_to_s;
   logic              ill_to_s;

   logic              sel_valid;
   event_t            sel_kind;
   logic [XLEN-1:0]   sel_code;
   logic [XLEN-1:0]   sel_tval;
   logic              sel_to_s;
   logic [XLEN-1:0]   sel_tvec;

   event_t            ev_kind;
   logic [XLEN-1:0]   ev_code;
   logic [XLEN-1:0]   ev_pc;
   logic [XLEN-1:0]   ev_tval;
   logic [XLEN-1:0]   ev_tvec;
   logic              ev_to_s;

   logic [XLEN-1:0]   vec_base;
   logic [XLEN-1:0]   trap_target;
   logic [XLEN-1:0]   cause_val;
   logic [XLEN-1:0]   trap_tval;

   // Only the upper tvec bits and the low cause-line slices of the delegation masks matter.
   logic              unused_inputs;
   assign unused_inputs = ^{medeleg, mideleg, ev_tvec[1]};

   // Lowest-index exception wins; delegation to S is only possible below M.
   always_comb begin
      exc_hit  = 1'b0;
      exc_code = '0;
      exc_to_s = 1'b0;
      for (int i = NUM_EXC - 1; i >= 0; i--) begin
         if (exc_req[i]) begin
            exc_hit  = 1'b1;
            exc_code = XLEN'(i);
            exc_to_s = medeleg[i] && (priv_mode != PRIV_M);
         end
      end
   end

   // Lowest-index interrupt that is eligible at the current privilege wins; others stay pending.
   always_comb begin
      irq_hit  = 1'b0;
      irq_code = '0;
      irq_to_s = 1'b0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq_req[i]) begin
            if (mideleg[i] && (priv_mode != PRIV_M)) begin
               if ((priv_mode == PRIV_U) || ((priv_mode == PRIV_S) && sie_g)) begin
                  irq_hit  = 1'b1;
                  irq_code = XLEN'(i);
                  irq_to_s = 1'b1;
               end
            end else if ((priv_mode != PRIV_M) || mie_g) begin
               irq_hit  = 1'b1;
               irq_code = XLEN'(i);
               irq_to_s = 1'b0;
            end
         end
      end
   end

   assign ill_to_s = medeleg[2] && (priv_mode != PRIV_M);

   // Same-cycle priority: exception, mret, sret, interrupt; illegal xRETs become cause 2.
   always_comb begin
      sel_valid = 1'b0;
      sel_kind  = EV_EXC;
      sel_code  = '0;
      sel_tval  = '0;
      sel_to_s  = 1'b0;
      if (exc_hit) begin
         sel_valid = 1'b1;
         sel_code  = exc_code;
         sel_tval  = exc_tval;
         sel_to_s  = exc_to_s;
      end else if (mret) begin
         sel_valid = 1'b1;
         if (priv_mode != PRIV_M) begin
            sel_code = XLEN'(2);
            sel_to_s = ill_to_s;
         end else begin
            sel_kind = EV_MRET;
         end
      end else if (sret) begin
         sel_valid = 1'b1;
         if (priv_mode == PRIV_U) begin
            sel_code = XLEN'(2);
            sel_to_s = ill_to_s;
         end else begin
            sel_kind = EV_SRET;
         end
      end else if (irq_hit) begin
         sel_valid = 1'b1;
         sel_kind  = EV_IRQ;
         sel_code  = irq_code;
         sel_to_s  = irq_to_s;
      end
   end

   assign sel_tvec = sel_to_s ? stvec : mtvec;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and strobe decode; flush and redirect_valid come straight from the state.
   always_comb begin
      state_next     = state;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      case (state)
         IDLE: begin
            if (sel_valid) begin
               state_next = FLUSH;
            end
         end
         FLUSH: begin
            flush = 1'b1;
            if (flush_ack) begin
               state_next = COMMIT;
            end
         end
         COMMIT: begin
            state_next = REDIRECT;
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            state_next     = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

   // Capture the whole event at selection so the pipeline inputs can change while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ev_kind <= EV_EXC;
         ev_code <= '0;
         ev_pc   <= '0;
         ev_tval <= '0;
         ev_tvec <= '0;
         ev_to_s <= 1'b0;
      end else if ((state == IDLE) && sel_valid) begin
         ev_kind <= sel_kind;
         ev_code <= sel_code;
         ev_pc   <= cur_pc;
         ev_tval <= sel_tval;
         ev_tvec <= sel_tvec;
         ev_to_s <= sel_to_s;
      end
   end

   assign vec_base    = {ev_tvec[XLEN-1:2], 2'b00};
   assign trap_target = ((ev_kind == EV_IRQ) && ev_tvec[0]) ? (vec_base + (ev_code << 2)) : vec_base;
   assign cause_val   = {(ev_kind == EV_IRQ), ev_code[XLEN-2:0]};
   assign trap_tval   = (ev_kind == EV_IRQ) ? '0 : ev_tval;

   // Trap CSR state, status stack, privilege and redirect target all update in COMMIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         priv_mode   <= PRIV_M;
         mepc        <= '0;
         mcause      <= '0;
         mtval       <= '0;
         sepc        <= '0;
         scause      <= '0;
         stval       <= '0;
         mie_g       <= 1'b0;
         mpie        <= 1'b0;
         sie_g       <= 1'b0;
         spie        <= 1'b0;
         mpp         <= PRIV_U;
         spp         <= 1'b0;
         redirect_pc <= '0;
      end else if (state == COMMIT) begin
         case (ev_kind)
            EV_EXC, EV_IRQ: begin
               redirect_pc <= trap_target;
               if (ev_to_s) begin
                  sepc      <= ev_pc;
                  scause    <= cause_val;
                  stval     <= trap_tval;
                  spie      <= sie_g;
                  sie_g     <= 1'b0;
                  spp       <= priv_mode[0];
                  priv_mode <= PRIV_S;
               end else begin
                  mepc      <= ev_pc;
                  mcause    <= cause_val;
                  mtval     <= trap_tval;
                  mpie      <= mie_g;
                  mie_g     <= 1'b0;
                  mpp       <= priv_mode;
                  priv_mode <= PRIV_M;
               end
            end
            EV_MRET: begin
               redirect_pc <= mepc;
               priv_mode   <= mpp;
               mie_g       <= mpie;
               mpie        <= 1'b1;
               mpp         <= PRIV_U;
            end
            EV_SRET: begin
               redirect_pc <= sepc;
               priv_mode   <= {1'b0, spp};
               sie_g       <= spie;
               spie        <= 1'b1;
               spp         <= 1'b0;
            end
            default: begin
               redirect_pc <= redirect_pc;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed and randomized events checked against a behavioural
// model of the privilege / trap CSR rules.
module tb_trap_sequencer;

   localparam int XLEN    = 32;
   localparam int NUM_EXC = 16;
   localparam int NUM_IRQ = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_EXC-1:0] exc_req;
   logic [NUM_IRQ-1:0] irq_req;
   logic [XLEN-1:0]    cur_pc, exc_tval, mtvec, stvec, medeleg, mideleg;
   logic               mret, sret, flush_ack;
   logic               flush, redirect_valid, busy;
   logic [XLEN-1:0]    redirect_pc;
   logic [1:0]         priv_mode;
   logic [XLEN-1:0]    mepc, mcause, mtval, sepc, scause, stval;
   logic               mie_g, mpie, sie_g, spie;
   logic [1:0]         mpp;
   logic               spp;

   trap_sequencer #(.XLEN(XLEN), .NUM_EXC(NUM_EXC), .NUM_IRQ(NUM_IRQ)) dut (
      .clk(clk), .rst(rst), .exc_req(exc_req), .irq_req(irq_req), .cur_pc(cur_pc),
      .exc_tval(exc_tval), .mret(mret), .sret(sret), .mtvec(mtvec), .stvec(stvec),
      .medeleg(medeleg), .mideleg(mideleg), .flush_ack(flush_ack), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
      .priv_mode(priv_mode), .mepc(mepc), .mcause(mcause), .mtval(mtval), .sepc(sepc),
      .scause(scause), .stval(stval), .mie_g(mie_g), .mpie(mpie), .sie_g(sie_g),
      .spie(spie), .mpp(mpp), .spp(spp)
   );

   always #5 clk = ~clk;

   int num_checks = 0;
   int num_errors = 0;

   // Reference model of the architectural state
   logic [1:0]      m_priv;
   logic [XLEN-1:0] m_mepc, m_mcause, m_mtval, m_sepc, m_scause, m_stval, m_redirect;
   logic            m_mie, m_mpie, m_sie, m_spie, m_spp;
   logic [1:0]      m_mpp;

   task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed, input logic [XLEN-1:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      m_priv = 2'b11;
      m_mepc = '0; m_mcause = '0; m_mtval = '0;
      m_sepc = '0; m_scause = '0; m_stval = '0;
      m_mie = 1'b0; m_mpie = 1'b0; m_sie = 1'b0; m_spie = 1'b0;
      m_mpp = 2'b00; m_spp = 1'b0;
      m_redirect = '0;
   endtask

   task automatic checkCsrs();
      checkOutput("priv", XLEN'(priv_mode), XLEN'(m_priv));
      checkOutput("mepc", mepc, m_mepc);
      checkOutput("mcause", mcause, m_mcause);
      checkOutput("mtval", mtval, m_mtval);
      checkOutput("sepc", sepc, m_sepc);
      checkOutput("scause", scause, m_scause);
      checkOutput("stval", stval, m_stval);
      checkOutput("status", XLEN'({mie_g, mpie, sie_g, spie, mpp, spp}),
                  XLEN'({m_mie, m_mpie, m_sie, m_spie, m_mpp, m_spp}));
   endtask

   task automatic checkReset();
      checkOutput("rst_flush", XLEN'(flush), '0);
      checkOutput("rst_busy", XLEN'(busy), '0);
      checkOutput("rst_rv", XLEN'(redirect_valid), '0);
      checkOutput("rst_rpc", redirect_pc, '0);
      checkCsrs();
   endtask

   task automatic clearRequests();
      exc_req = '0; irq_req = '0; mret = 1'b0; sret = 1'b0;
   endtask

   task automatic scrambleInputs();
      exc_req  = NUM_EXC'($urandom); irq_req = NUM_IRQ'($urandom);
      mret     = 1'($urandom);       sret    = 1'($urandom);
      cur_pc   = $urandom; exc_tval = $urandom; mtvec = $urandom; stvec = $urandom;
      medeleg  = $urandom; mideleg  = $urandom;
   endtask

   task automatic doReset();
      rst = 1'b1;
      clearRequests();
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      checkReset();
   endtask

   // Called at a negedge with the DUT idle: present one request set, follow the event through.
   task automatic applyStimulus(input logic [NUM_EXC-1:0] e, input logic [NUM_IRQ-1:0] q,
                                input logic mr, input logic sr, input logic [XLEN-1:0] pc,
                                input logic [XLEN-1:0] tv, input logic [XLEN-1:0] mt,
                                input logic [XLEN-1:0] st, input logic [XLEN-1:0] med,
                                input logic [XLEN-1:0] mid, input int ack_delay);
      int              kind;   // 0 none, 1 exception, 2 interrupt, 3 mret, 4 sret
      int              code;
      bit              to_s;
      logic [XLEN-1:0] tval_x, tvec, base, cause;
      logic [1:0]      old_priv;
      kind = 0; code = 0; to_s = 1'b0; tval_x = '0;
      if (e != '0) begin
         for (int i = 0; i < NUM_EXC; i++) if (e[i]) begin code = i; break; end
         kind = 1; tval_x = tv;
      end else if (mr) begin
         if (m_priv != 2'b11) begin kind = 1; code = 2; end else kind = 3;
      end else if (sr) begin
         if (m_priv == 2'b00) begin kind = 1; code = 2; end else kind = 4;
      end else begin
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (q[i]) begin
               to_s = mid[i] && (m_priv != 2'b11);
               if (to_s ? ((m_priv == 2'b00) || (m_priv == 2'b01 && m_sie))
                        : ((m_priv != 2'b11) || m_mie)) begin
                  kind = 2; code = i; break;
               end
            end
         end
      end
      if (kind == 1) to_s = med[code] && (m_priv != 2'b11);
      tvec = to_s ? st : mt;
      base = tvec - (tvec % 4);
      if (kind == 1) m_redirect = base;
      if (kind == 2) m_redirect = tvec[0] ? base + XLEN'(4 * code) : base;
      if (kind == 3) m_redirect = m_mepc;
      if (kind == 4) m_redirect = m_sepc;
      old_priv = m_priv;
      if (kind == 1 || kind == 2) begin
         cause = XLEN'(code);
         if (kind == 2) cause[XLEN-1] = 1'b1;
         if (to_s) begin
            m_sepc = pc; m_scause = cause; m_stval = (kind == 1) ? tval_x : '0;
            m_spie = m_sie; m_sie = 1'b0; m_spp = m_priv[0]; m_priv = 2'b01;
         end else begin
            m_mepc = pc; m_mcause = cause; m_mtval = (kind == 1) ? tval_x : '0;
            m_mpie = m_mie; m_mie = 1'b0; m_mpp = m_priv; m_priv = 2'b11;
         end
      end else if (kind == 3) begin
         m_priv = m_mpp; m_mie = m_mpie; m_mpie = 1'b1; m_mpp = 2'b00;
      end else if (kind == 4) begin
         m_priv = {1'b0, m_spp}; m_sie = m_spie; m_spie = 1'b1; m_spp = 1'b0;
      end

      exc_req = e; irq_req = q; mret = mr; sret = sr; cur_pc = pc; exc_tval = tv;
      mtvec = mt; stvec = st; medeleg = med; mideleg = mid;
      @(posedge clk); @(negedge clk);
      if (kind == 0) begin
         checkOutput("noevent_busy", XLEN'(busy), '0);
         checkOutput("noevent_priv", XLEN'(priv_mode), XLEN'(m_priv));
         return;
      end
      for (int c = 0; c <= ack_delay; c++) begin
         scrambleInputs();
         flush_ack = (c >= ack_delay);
         checkOutput("flush_on", XLEN'(flush), 32'd1);
         checkOutput("busy_on", XLEN'(busy), 32'd1);
         @(posedge clk); @(negedge clk);
      end
      checkOutput("commit_flush", XLEN'(flush), '0);
      checkOutput("commit_rv", XLEN'(redirect_valid), '0);
      checkOutput("commit_priv", XLEN'(priv_mode), XLEN'(old_priv));
      scrambleInputs();
      flush_ack = 1'($urandom);
      @(posedge clk); @(negedge clk);
      clearRequests();
      checkOutput("redirect_rv", XLEN'(redirect_valid), 32'd1);
      checkOutput("redirect_pc", redirect_pc, m_redirect);
      checkCsrs();
      @(posedge clk); @(negedge clk);
      checkOutput("idle_rv", XLEN'(redirect_valid), '0);
      checkOutput("idle_busy", XLEN'(busy), '0);
   endtask

   initial begin
      logic [NUM_EXC-1:0] e;
      logic [NUM_IRQ-1:0] q;
      logic               mr, sr;
      int                 sel;

      rst = 1'b1;
      clearRequests();
      cur_pc = '0; exc_tval = '0; mtvec = '0; stvec = '0; medeleg = '0; mideleg = '0;
      flush_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      doReset();

      applyStimulus(16'h0004, '0, 0, 0, 32'h100, 32'hDEAD, 32'h8000_0001, 32'h0, 32'h0, 32'h0, 0);
      checkOutput("plan_mcause", mcause, 32'h2);
      checkOutput("plan_mepc", mepc, 32'h100);
      checkOutput("plan_mtval", mtval, 32'hDEAD);
      checkOutput("plan_rpc", redirect_pc, 32'h8000_0000);

      doReset();
      applyStimulus('0, '0, 1, 0, 32'h0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 1);
      applyStimulus('0, 16'h0080, 0, 0, 32'h140, 32'h55, 32'h8000_0001, 32'h0, 32'h0, 32'h0, 0);
      checkOutput("plan_irq_mcause", mcause, 32'h8000_0007);
      checkOutput("plan_irq_rpc", redirect_pc, 32'h8000_001C);
      checkOutput("plan_irq_mtval", mtval, 32'h0);
      applyStimulus(16'h0010, 16'h0008, 0, 0, 32'h180, 32'h77, 32'h1000, 32'h0, 32'h0, 32'h0, 2);
      checkOutput("plan_prio_mcause", mcause, 32'h4);
      applyStimulus('0, 16'h0008, 0, 0, 32'h1C0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 0);
      applyStimulus('0, 16'h0008, 1, 0, 32'h1C0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 0);
      applyStimulus('0, 16'h0008, 0, 0, 32'h1C0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 0);
      applyStimulus('0, 16'h0008, 1, 0, 32'h1C0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 0);
      applyStimulus('0, 16'h0008, 0, 0, 32'h1E0, 32'h0, 32'h1001, 32'h0, 32'h0, 32'h0, 0);
      checkOutput("plan_held_irq", mcause, 32'h8000_0003);
      applyStimulus('0, '0, 0, 1, 32'h0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 0);
      applyStimulus('0, '0, 0, 1, 32'h240, 32'h99, 32'h1000, 32'h0, 32'h0, 32'h0, 1);
      checkOutput("plan_sret_u_mcause", mcause, 32'h2);
      checkOutput("plan_sret_u_mtval", mtval, 32'h0);
      applyStimulus('0, '0, 1, 0, 32'h0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 0);
      applyStimulus(16'h0020, '0, 0, 0, 32'h280, 32'h1, 32'h1000, 32'h4000, 32'h20, 32'h0, 0);
      applyStimulus(16'h0100, '0, 0, 0, 32'h300, 32'h2, 32'h1000, 32'h4000, 32'h100, 32'h0, 0);
      checkOutput("plan_s_scause", scause, 32'h8);
      checkOutput("plan_s_sepc", sepc, 32'h300);
      checkOutput("plan_s_priv", XLEN'(priv_mode), 32'h1);
      checkOutput("plan_s_spp", XLEN'(spp), 32'h1);
      checkOutput("plan_s_rpc", redirect_pc, 32'h4000);
      applyStimulus(16'h0002, '0, 0, 0, 32'h200, 32'h3, 32'h1000, 32'h4000, 32'h0, 32'h0, 0);
      applyStimulus('0, '0, 1, 0, 32'h0, 32'h0, 32'h1000, 32'h4000, 32'h0, 32'h0, 0);
      checkOutput("plan_mret_priv", XLEN'(priv_mode), 32'h1);
      checkOutput("plan_mret_rpc", redirect_pc, 32'h200);
      checkOutput("plan_mret_mpp", XLEN'(mpp), 32'h0);
      checkOutput("plan_mret_mpie", XLEN'(mpie), 32'h1);
      applyStimulus(16'h0001, '0, 0, 0, 32'h320, 32'h4, 32'h1000, 32'h4000, 32'h0, 32'h0, 0);
      applyStimulus(16'h0100, '0, 0, 0, 32'h340, 32'h5, 32'h1000, 32'h4000, 32'h100, 32'h0, 0);
      checkOutput("plan_m_mcause", mcause, 32'h8);

      for (int n = 0; n < 300; n++) begin
         e = '0; q = '0; mr = 1'b0; sr = 1'b0;
         sel = $urandom_range(0, 9);
         if (sel <= 2) begin
            e = NUM_EXC'(1) << $urandom_range(0, NUM_EXC - 1);
            if ($urandom_range(0, 1) == 1) e = e | NUM_EXC'($urandom);
         end else if (sel <= 4) begin
            mr = 1'b1;
         end else if (sel == 5) begin
            sr = 1'b1;
         end else if (sel <= 8) begin
            q = NUM_IRQ'($urandom) & NUM_IRQ'($urandom);
         end else begin
            e = NUM_EXC'($urandom) & NUM_EXC'($urandom) & NUM_EXC'($urandom);
            mr = 1'($urandom); sr = 1'($urandom);
         end
         if (sel <= 5 && $urandom_range(0, 2) == 0) q = NUM_IRQ'($urandom);
         applyStimulus(e, q, mr, sr, $urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom_range(0, 3));
      end

      exc_req = 16'h0008; cur_pc = 32'h900; exc_tval = 32'h1234; mtvec = 32'h2000;
      medeleg = '0; flush_ack = 1'b0;
      @(posedge clk); @(negedge clk);
      clearRequests();
      for (int c = 0; c < 5; c++) begin
         checkOutput("rstflush_flush", XLEN'(flush), 32'd1);
         @(posedge clk); @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      modelReset();
      checkReset();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(16'h0001, '0, 0, 0, 32'hA00, 32'h6, 32'h3000, 32'h0, 32'h0, 32'h0, 1);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
